// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: pipeline request, data-memory port and pipeline control
// signals of the MEM-stage access controller.
interface dmem_access_ctrl_if;
   logic [31:0] mem_alu_out;
   logic [31:0] mem_store_data;
   logic        mem_data_mem_read;
   logic        mem_data_mem_write;
   logic [2:0]  mem_funct3;
   logic        dmem_ack;
   logic [31:0] dmem_read_data;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_write_data;
   logic [3:0]  dmem_byte_en;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] mem_data_mem_read_data;
   logic        stall;
   logic        mem_fault;
   logic        bus_error;
   modport slave (
      input  mem_alu_out, mem_store_data, mem_data_mem_read, mem_data_mem_write,
             mem_funct3, dmem_ack, dmem_read_data,
      output dmem_addr, dmem_write_data, dmem_byte_en, dmem_read, dmem_write,
             mem_data_mem_read_data, stall, mem_fault, bus_error
   );
   modport master (
      output mem_alu_out, mem_store_data, mem_data_mem_read, mem_data_mem_write,
             mem_funct3, dmem_ack, dmem_read_data,
      input  dmem_addr, dmem_write_data, dmem_byte_en, dmem_read, dmem_write,
             mem_data_mem_read_data, stall, mem_fault, bus_error
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store controller; issues aligned byte-enabled
// req/ack accesses, formats load data, stalls the pipeline and aborts on timeout.
module dmem_access_ctrl #(
   parameter int TIMEOUT = 255
) (
   input logic              i_clk,
   input logic              i_rst,
   dmem_access_ctrl_if.slave io_bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t      r_state, w_next;
   logic [9:0]  r_cnt;
   logic [31:0] r_addr, r_wdata, r_res;
   logic [3:0]  r_be;
   logic [2:0]  r_f3;
   logic [1:0]  r_lane;
   logic        r_rd, r_wr, r_load, r_bus_err;
   logic        w_rd, w_wr, w_illegal, w_misalign, w_fault, w_go, w_ack, w_timeout;
   logic [2:0]  w_f3;
   logic [1:0]  w_a;
   logic [31:0] w_d, w_rdata, w_fmt;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_rd  = io_bus.mem_data_mem_read;
   assign w_wr  = io_bus.mem_data_mem_write;
   assign w_f3  = io_bus.mem_funct3;
   assign w_a   = io_bus.mem_alu_out[1:0];
   assign w_d   = io_bus.mem_store_data;
   assign w_rdata = io_bus.dmem_read_data;
   // loads reject 011/11x, stores reject 011/1xx; both strobes high is caught separately
   assign w_illegal  = w_rd ? ((w_f3 == 3'b011) | (w_f3[2] & w_f3[1])) : (w_f3[2] | (&w_f3[1:0]));
   assign w_misalign = ((w_f3[1:0] == 2'b01) & w_a[0]) | ((w_f3[1:0] == 2'b10) & (|w_a));
   assign w_fault    = (w_rd | w_wr) & ((w_rd & w_wr) | w_illegal | w_misalign);

   assign w_byte = w_rdata[{r_lane, 3'b000} +: 8];
   assign w_half = r_lane[1] ? w_rdata[31:16] : w_rdata[15:0];
   assign w_fmt  = r_f3[1] ? w_rdata :
                   r_f3[0] ? {{16{~r_f3[2] & w_half[15]}}, w_half} :
                             {{24{~r_f3[2] & w_byte[7]}}, w_byte};

   always_comb begin
      w_next    = r_state;
      w_go      = 1'b0;
      w_ack     = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            w_go   = (w_rd ^ w_wr) & ~w_fault;
            w_next = w_go ? WAIT : IDLE;
         end
         WAIT: begin
            w_ack     = io_bus.dmem_ack;
            w_timeout = ~w_ack & (r_cnt == 10'(TIMEOUT - 1));
            w_next    = (w_ack | w_timeout) ? DONE : WAIT;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_res     <= '0;
         r_cnt     <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_load    <= 1'b0;
         r_bus_err <= 1'b0;
         r_f3      <= '0;
         r_lane    <= '0;
      end else begin
         r_bus_err <= w_timeout;
         if (w_go) begin
            r_addr  <= {io_bus.mem_alu_out[31:2], 2'b00};
            r_wdata <= w_f3[1] ? w_d : w_f3[0] ? {2{w_d[15:0]}} : {4{w_d[7:0]}};
            r_be    <= w_f3[1] ? 4'b1111 : w_f3[0] ? 4'b0011 << w_a : 4'b0001 << w_a;
            r_rd    <= w_rd;
            r_wr    <= w_wr;
            r_load  <= w_rd;
            r_f3    <= w_f3;
            r_lane  <= w_a;
            r_cnt   <= '0;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 10'd1;
            if (w_ack | w_timeout) begin
               r_rd  <= 1'b0;
               r_wr  <= 1'b0;
               r_res <= (w_ack & r_load) ? w_fmt : '0;
            end
         end
      end
   end

   assign io_bus.dmem_addr              = r_addr;
   assign io_bus.dmem_write_data        = r_wdata;
   assign io_bus.dmem_byte_en           = r_be;
   assign io_bus.dmem_read              = r_rd;
   assign io_bus.dmem_write             = r_wr;
   assign io_bus.bus_error              = r_bus_err;
   assign io_bus.mem_data_mem_read_data = (r_state == DONE) ? r_res : '0;
   assign io_bus.stall                  = ~i_rst & (w_go | (r_state == WAIT));
   assign io_bus.mem_fault              = ~i_rst & (r_state == IDLE) & w_fault;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: vector table plus hand-written sequences for timeout and
// mid-access reset; expected results flow through a scoreboard queue.
module tb_dmem_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl_if bus ();

   dmem_access_ctrl #(.TIMEOUT(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_bus(bus)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] word;
      int          dly;
      logic        fault;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_res;
   } vec_t;

   vec_t vecs[17];
   vec_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bus.mem_data_mem_read  = 1'b0;
      bus.mem_data_mem_write = 1'b0;
      bus.mem_funct3         = 3'b000;
      bus.mem_alu_out        = '0;
      bus.mem_store_data     = '0;
   endtask

   task automatic drive(input vec_t v);
      bus.mem_data_mem_read  = v.rd;
      bus.mem_data_mem_write = v.wr;
      bus.mem_funct3         = v.f3;
      bus.mem_alu_out        = v.addr;
      bus.mem_store_data     = v.sdata;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   n;
      bit   done;
      vec_t e;
      @(negedge clk);
      drive(v);
      #1;
      chk($sformatf("v%0d fault", idx), bus.mem_fault, v.fault);
      chk($sformatf("v%0d stall_idle", idx), bus.stall, !v.fault && (v.rd ^ v.wr));
      if (v.fault || !(v.rd ^ v.wr)) begin
         @(negedge clk);
         #1;
         chk($sformatf("v%0d no_stall", idx), bus.stall, 1'b0);
         chk($sformatf("v%0d no_strobe", idx), {bus.dmem_read, bus.dmem_write}, 2'b00);
         clear_inputs();
         return;
      end
      sb.push_back(v);
      n = 1;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         bus.dmem_ack = 1'b0;
         #1;
         if (!bus.stall) done = 1;
         else begin
            n++;
            if (c == 0) begin
               chk($sformatf("v%0d addr", idx), bus.dmem_addr, v.e_addr);
               if (v.wr) begin
                  chk($sformatf("v%0d be", idx), bus.dmem_byte_en, v.e_be);
                  chk($sformatf("v%0d wdata", idx), bus.dmem_write_data, v.e_wdata);
               end
            end
            chk($sformatf("v%0d strobes", idx), {bus.dmem_read, bus.dmem_write}, {v.rd, v.wr});
            bus.dmem_ack       = (c == v.dly);
            bus.dmem_read_data = v.word;
         end
      end
      if (!done) begin
         bad++;
         total++;
         $display("FAIL v%0d done_wait: no DONE within 20 cycles", idx);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         chk($sformatf("v%0d rdata", idx), bus.mem_data_mem_read_data, e.e_res);
         chk($sformatf("v%0d stall_cycles", idx), n, e.dly + 2);
         chk($sformatf("v%0d done_strobes", idx), {bus.dmem_read, bus.dmem_write, bus.bus_error}, 3'b000);
      end
      clear_inputs();
   endtask

   initial begin
      int  n;
      bit  done;
      clear_inputs();
      bus.dmem_ack       = 1'b0;
      bus.dmem_read_data = '0;
      //            rd   wr   f3      addr          sdata         word          dly fault e_addr        be       wdata         res
      vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'hDEAD_BEEF};
      vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_0100, 4'h8, 32'h0,        32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 1'b0, 32'h0000_0100, 4'h8, 32'h0,        32'h0000_0080};
      vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'hFFFF_FFFF, 2, 1'b0, 32'h0000_0200, 4'hC, 32'hABCD_ABCD, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_0100, 4'hC, 32'h0,        32'hFFFF_80FF};
      vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h80FF_9234, 0, 1'b0, 32'h0000_0100, 4'h3, 32'h0,        32'h0000_9234};
      vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 1'b0, 32'h0000_0300, 4'h2, 32'hA5A5_A5A5, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_040C, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 1'b0, 32'h0000_040C, 4'hF, 32'hCAFE_F00D, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_0100, 4'h2, 32'h0,        32'h0000_0012};
      vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'h1357_9BDF, 3, 1'b0, 32'h0000_0104, 4'hF, 32'h0,        32'h1357_9BDF};
      vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0};
      vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0};
      vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0};
      vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0};
      vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0};
      vecs[15] = '{1'b0, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b0, 32'h0,         4'h0, 32'h0,        32'h0};
      vecs[16] = '{1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0};

      // reset: a faulting request must not raise MEM_FAULT or STALL while RESET is high
      bus.mem_data_mem_read  = 1'b1;
      bus.mem_data_mem_write = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst fault", bus.mem_fault, 1'b0);
      chk("rst stall", bus.stall, 1'b0);
      chk("rst outs", {bus.dmem_read, bus.dmem_write, bus.bus_error, bus.dmem_byte_en}, 7'd0);
      chk("rst addr", bus.dmem_addr, 32'h0);
      chk("rst wdata", bus.dmem_write_data, 32'h0);
      chk("rst rdata", bus.mem_data_mem_read_data, 32'h0);
      clear_inputs();
      rst = 1'b0;

      for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

      // timeout: no ACK, BUS_ERROR in cycle 6 counting the IDLE request cycle as 1
      @(negedge clk);
      bus.mem_data_mem_read = 1'b1;
      bus.mem_funct3        = 3'b010;
      bus.mem_alu_out       = 32'h0000_0100;
      #1;
      chk("to stall_idle", bus.stall, 1'b1);
      n = 1;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         #1;
         n++;
         if (!bus.stall) done = 1;
         else chk("to bus_err_early", bus.bus_error, 1'b0);
      end
      chk("to done_cycle", n, 6);
      chk("to bus_err", bus.bus_error, 1'b1);
      chk("to rdata", bus.mem_data_mem_read_data, 32'h0);
      chk("to strobes", bus.dmem_read, 1'b0);
      clear_inputs();
      @(negedge clk);
      #1;
      chk("to bus_err_pulse", bus.bus_error, 1'b0);
      chk("to idle_stall", bus.stall, 1'b0);

      // reset in the 2nd WAIT cycle, then a late ACK
      @(negedge clk);
      bus.mem_data_mem_write = 1'b1;
      bus.mem_funct3         = 3'b010;
      bus.mem_alu_out        = 32'h0000_0500;
      bus.mem_store_data     = 32'h1111_2222;
      @(negedge clk);
      #1;
      chk("mr wait1_write", bus.dmem_write, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mr wait2_stall", bus.stall, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      bus.dmem_ack       = 1'b1;
      bus.dmem_read_data = 32'h5555_AAAA;
      #1;
      chk("mr strobes", {bus.dmem_read, bus.dmem_write, bus.bus_error}, 3'b000);
      chk("mr stall", bus.stall, 1'b0);
      chk("mr addr", bus.dmem_addr, 32'h0);
      chk("mr wdata", bus.dmem_write_data, 32'h0);
      chk("mr be", bus.dmem_byte_en, 4'h0);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      #1;
      chk("mr ack_ignored_rdata", bus.mem_data_mem_read_data, 32'h0);
      chk("mr ack_ignored_stall", bus.stall, 1'b0);
      chk("mr ack_ignored_strobes", {bus.dmem_read, bus.dmem_write}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
